// File: rtl/stft_pkg.sv
// Shared types and width helpers for the multi-channel sliding-DFT sequencer.
package stft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } stft_state_e;

    // Index width for a count of n items; a single item still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int disp_cnt_w(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/stft_sdft_sequencer_ch_ctx.sv
// Per-channel context bank: ring write pointer and display counter for each channel.
module stft_ch_ctx
    import stft_pkg::*;
#(
    parameter  int NUM_CH      = 2,
    parameter  int FFT_SIZE    = 256,
    parameter  int DISP_PERIOD = 4410,
    localparam int CH_W        = idx_w(NUM_CH),
    localparam int AW          = idx_w(FFT_SIZE),
    localparam int DW          = disp_cnt_w(DISP_PERIOD)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CH_W-1:0] rd_ch,
    output logic [AW-1:0]   rd_ptr,
    output logic [DW-1:0]   rd_disp_cnt,
    input  logic            inc_en,
    input  logic [CH_W-1:0] inc_ch
);

    logic [AW-1:0] wr_ptr_q   [NUM_CH];
    logic [AW-1:0] wr_ptr_d   [NUM_CH];
    logic [DW-1:0] disp_cnt_q [NUM_CH];
    logic [DW-1:0] disp_cnt_d [NUM_CH];

    // FFT_SIZE is a power of two, so the pointer wraps naturally.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr_d[c]   = wr_ptr_q[c];
            disp_cnt_d[c] = disp_cnt_q[c];
            if (inc_en && (int'(inc_ch) == c)) begin
                wr_ptr_d[c]   = wr_ptr_q[c] + AW'(1);
                disp_cnt_d[c] = (disp_cnt_q[c] == DW'(DISP_PERIOD - 1)) ? '0
                                                                         : disp_cnt_q[c] + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) begin
                wr_ptr_q[c]   <= '0;
                disp_cnt_q[c] <= '0;
            end else begin
                wr_ptr_q[c]   <= wr_ptr_d[c];
                disp_cnt_q[c] <= disp_cnt_d[c];
            end
        end
    end

    always_comb begin
        rd_ptr      = '0;
        rd_disp_cnt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(rd_ch) == c) begin
                rd_ptr      = wr_ptr_q[c];
                rd_disp_cnt = disp_cnt_q[c];
            end
        end
    end

endmodule

// File: rtl/stft_sdft_sequencer.sv
// Multi-channel sliding-DFT sequencer: ring read/write, sample difference, bin sweep, display flags.
// STFT_DIFF_SAT_EN clamps sample_diff to the signed WORD_WIDTH range.
module stft_sdft_sequencer
    import stft_pkg::*;
#(
    parameter  int WORD_WIDTH  = 16,
    parameter  int FFT_SIZE    = 256,
    parameter  int NUM_CH      = 2,
    parameter  int DISP_PERIOD = 4410,
    localparam int CH_W        = idx_w(NUM_CH),
    localparam int AW          = idx_w(FFT_SIZE)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    input  logic [CH_W-1:0]        sample_ch,
    input  logic [WORD_WIDTH-1:0]  sample,
    output logic [CH_W+AW-1:0]     ring_rd_addr,
    input  logic [WORD_WIDTH-1:0]  oldest_sample,
    output logic                   ring_wr_en,
    output logic [CH_W+AW-1:0]     ring_wr_addr,
    output logic [WORD_WIDTH-1:0]  ring_wr_data,
    output logic [WORD_WIDTH:0]    sample_diff,
    output logic                   bin_valid,
    output logic [AW-1:0]          bin_idx,
    output logic [CH_W-1:0]        bin_ch,
    output logic                   disp_wr_en,
    output logic                   frame_done,
    output logic                   ch_err
);

    localparam int DW = disp_cnt_w(DISP_PERIOD);
    localparam int W  = WORD_WIDTH;

    stft_state_e         state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [W-1:0]        sample_q, sample_d;
    logic [AW-1:0]       bin_idx_q, bin_idx_d;
    logic [W:0]          sample_diff_q, sample_diff_d;
    logic                ready_q, ready_d;
    logic                wr_en_q, wr_en_d;
    logic [CH_W+AW-1:0]  wr_addr_q, wr_addr_d;
    logic                bin_valid_q, bin_valid_d;
    logic                disp_q, disp_d;
    logic                frame_done_q, frame_done_d;
    logic                ch_err_q, ch_err_d;

    logic [CH_W-1:0]     in_ch;
    logic                ch_legal;
    logic [CH_W-1:0]     rd_ch;
    logic [AW-1:0]       rd_ptr;
    logic [DW-1:0]       rd_disp_cnt;
    logic                inc_en;
    logic [W:0]          diff_full;
    logic [W:0]          diff_val;

    assign in_ch    = (NUM_CH == 1) ? '0 : sample_ch;
    assign ch_legal = (NUM_CH == 1) || (int'(sample_ch) < NUM_CH);
    assign rd_ch    = (state_q == IDLE) ? in_ch : ch_q;

    stft_ch_ctx #(
        .NUM_CH      (NUM_CH),
        .FFT_SIZE    (FFT_SIZE),
        .DISP_PERIOD (DISP_PERIOD)
    ) u_ch_ctx (
        .clk         (clk),
        .reset       (reset),
        .rd_ch       (rd_ch),
        .rd_ptr      (rd_ptr),
        .rd_disp_cnt (rd_disp_cnt),
        .inc_en      (inc_en),
        .inc_ch      (ch_q)
    );

    // The ring RAM has one cycle of read latency, so the read address is presented
    // combinationally during the handshake cycle to have oldest_sample ready in LOAD.
    assign ring_rd_addr = (state_q == IDLE && sample_valid && ch_legal) ? {in_ch, rd_ptr} : '0;

    assign diff_full = {sample_q[W-1], sample_q} - {oldest_sample[W-1], oldest_sample};

`ifdef STFT_DIFF_SAT_EN
    // Top two bits disagree exactly when the difference leaves the W-bit signed range.
    always_comb begin
        diff_val = diff_full;
        if (diff_full[W] != diff_full[W-1]) begin
            diff_val = diff_full[W] ? {2'b11, {(W-1){1'b0}}} : {2'b00, {(W-1){1'b1}}};
        end
    end
`else
    assign diff_val = diff_full;
`endif

    always_comb begin
        state_d       = state_q;
        ch_d          = ch_q;
        sample_d      = sample_q;
        bin_idx_d     = bin_idx_q;
        sample_diff_d = sample_diff_q;
        ready_d       = ready_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        bin_valid_d   = bin_valid_q;
        disp_d        = disp_q;
        frame_done_d  = 1'b0;
        ch_err_d      = 1'b0;
        inc_en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_valid && ready_q) begin
                    if (ch_legal) begin
                        ch_d      = in_ch;
                        sample_d  = sample;
                        wr_en_d   = 1'b1;
                        wr_addr_d = {in_ch, rd_ptr};
                        ready_d   = 1'b0;
                        state_d   = LOAD;
                    end else begin
                        ch_err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                sample_diff_d = diff_val;
                disp_d        = (rd_disp_cnt == DW'(DISP_PERIOD - 1));
                bin_idx_d     = '0;
                bin_valid_d   = 1'b1;
                state_d       = SWEEP;
            end
            SWEEP: begin
                if (bin_idx_q == AW'(FFT_SIZE - 1)) begin
                    inc_en       = 1'b1;
                    bin_idx_d    = '0;
                    bin_valid_d  = 1'b0;
                    disp_d       = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    bin_idx_d = bin_idx_q + AW'(1);
                end
            end
            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ch_q          <= '0;
            sample_q      <= '0;
            bin_idx_q     <= '0;
            sample_diff_q <= '0;
            ready_q       <= 1'b1;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            bin_valid_q   <= 1'b0;
            disp_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            ch_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_q          <= ch_d;
            sample_q      <= sample_d;
            bin_idx_q     <= bin_idx_d;
            sample_diff_q <= sample_diff_d;
            ready_q       <= ready_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            bin_valid_q   <= bin_valid_d;
            disp_q        <= disp_d;
            frame_done_q  <= frame_done_d;
            ch_err_q      <= ch_err_d;
        end
    end

    assign sample_ready = ready_q;
    assign ring_wr_en   = wr_en_q;
    assign ring_wr_addr = wr_addr_q;
    assign ring_wr_data = sample_q;
    assign sample_diff  = sample_diff_q;
    assign bin_valid    = bin_valid_q;
    assign bin_idx      = bin_idx_q;
    assign bin_ch       = ch_q;
    assign disp_wr_en   = disp_q;
    assign frame_done   = frame_done_q;
    assign ch_err       = ch_err_q;

endmodule

// File: tb/tb_stft_sdft_sequencer.sv
// Randomized bench for stft_sdft_sequencer against a ring/pointer/counter reference model.
module tb_stft_sdft_sequencer;

    localparam int W    = 16;
    localparam int F    = 16;
    localparam int NC   = 3;
    localparam int P    = 4;
    localparam int CH_W = 2;
    localparam int AW   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               sample_valid;
    logic               sample_ready;
    logic [CH_W-1:0]    sample_ch;
    logic [W-1:0]       sample;
    logic [CH_W+AW-1:0] ring_rd_addr;
    logic [W-1:0]       oldest_sample;
    logic               ring_wr_en;
    logic [CH_W+AW-1:0] ring_wr_addr;
    logic [W-1:0]       ring_wr_data;
    logic [W:0]         sample_diff;
    logic               bin_valid;
    logic [AW-1:0]      bin_idx;
    logic [CH_W-1:0]    bin_ch;
    logic               disp_wr_en;
    logic               frame_done;
    logic               ch_err;

    stft_sdft_sequencer #(
        .WORD_WIDTH  (W),
        .FFT_SIZE    (F),
        .NUM_CH      (NC),
        .DISP_PERIOD (P)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .sample_ch     (sample_ch),
        .sample        (sample),
        .ring_rd_addr  (ring_rd_addr),
        .oldest_sample (oldest_sample),
        .ring_wr_en    (ring_wr_en),
        .ring_wr_addr  (ring_wr_addr),
        .ring_wr_data  (ring_wr_data),
        .sample_diff   (sample_diff),
        .bin_valid     (bin_valid),
        .bin_idx       (bin_idx),
        .bin_ch        (bin_ch),
        .disp_wr_en    (disp_wr_en),
        .frame_done    (frame_done),
        .ch_err        (ch_err)
    );

    always #5 clk = ~clk;

    // External ring RAM with one-cycle synchronous read.
    logic [W-1:0] ram [64];
    initial for (int i = 0; i < 64; i++) ram[i] = '0;
    always @(posedge clk) begin
        if (ring_wr_en) ram[ring_wr_addr] <= ring_wr_data;
        oldest_sample <= ram[ring_rd_addr];
    end

    int n_vec = 0;
    int n_err = 0;

    int m_ptr  [NC];
    int m_disp [NC];
    int m_ring [NC][F];

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_diff(input int nv, input int ov);
        int d;
        d = nv - ov;
`ifdef STFT_DIFF_SAT_EN
        if (d > 32767)  d = 32767;
        if (d < -32768) d = -32768;
`endif
        return d;
    endfunction

    function automatic int rand_word();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_ptr[c]  = 0;
            m_disp[c] = 0;
        end
    endtask

    // Starts and ends just after a falling edge with the DUT idle.
    task automatic send_frame(input int ch, input int val, input bit hold, input int rst_at_bin);
        int ptr, exp_d;
        bit exp_disp;
        ptr = m_ptr[ch];
        sample_valid = 1'b1;
        sample_ch    = CH_W'(ch);
        sample       = W'(val);
        #1;
        check_val("ready_idle", sample_ready, 1);
        check_val("rd_addr", ring_rd_addr, ch * F + ptr);
        @(negedge clk);
        if (!hold) sample_valid = 1'b0;
        check_val("wr_en", ring_wr_en, 1);
        check_val("wr_addr", ring_wr_addr, ch * F + ptr);
        check_val("wr_data", $signed(ring_wr_data), val);
        check_val("ready_load", sample_ready, 0);
        exp_d    = ref_diff(val, m_ring[ch][ptr]);
        exp_disp = (m_disp[ch] == P - 1);
        m_ring[ch][ptr] = val;
        for (int k = 0; k < F; k++) begin
            @(negedge clk);
            if (k == rst_at_bin) begin
                reset        = 1'b1;
                sample_valid = 1'b0;
                @(negedge clk);
                reset = 1'b0;
                check_val("rst_ready", sample_ready, 1);
                check_val("rst_bin_valid", bin_valid, 0);
                check_val("rst_frame_done", frame_done, 0);
                check_val("rst_diff", $signed(sample_diff), 0);
                model_reset();
                return;
            end
            check_val("bin_valid", bin_valid, 1);
            check_val("bin_idx", bin_idx, k);
            check_val("bin_ch", bin_ch, ch);
            check_val("sweep_wr_en", ring_wr_en, 0);
            check_val("sweep_ready", sample_ready, 0);
            check_val("sweep_frame_done", frame_done, 0);
            if (k == 0 || k == F - 1) begin
                check_val("sample_diff", $signed(sample_diff), exp_d);
                check_val("disp_wr_en", disp_wr_en, exp_disp);
            end
        end
        @(negedge clk);
        sample_valid = 1'b0;
        check_val("done_frame_done", frame_done, 1);
        check_val("done_bin_valid", bin_valid, 0);
        check_val("done_disp", disp_wr_en, 0);
        check_val("done_ready", sample_ready, 0);
        m_ptr[ch]  = (m_ptr[ch] + 1) % F;
        m_disp[ch] = (m_disp[ch] + 1) % P;
        @(negedge clk);
        check_val("idle_ready", sample_ready, 1);
        check_val("idle_frame_done", frame_done, 0);
    endtask

    task automatic send_bad_ch();
        sample_valid = 1'b1;
        sample_ch    = CH_W'(3);
        sample       = W'(rand_word());
        @(negedge clk);
        sample_valid = 1'b0;
        check_val("ch_err_pulse", ch_err, 1);
        check_val("ch_err_wr_en", ring_wr_en, 0);
        check_val("ch_err_ready", sample_ready, 1);
        @(negedge clk);
        check_val("ch_err_clear", ch_err, 0);
        check_val("ch_err_wr_en2", ring_wr_en, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_ch    = '0;
        sample       = '0;
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < F; i++) m_ring[c][i] = 0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_val("reset_ready", sample_ready, 1);
        check_val("reset_bin_valid", bin_valid, 0);
        check_val("reset_wr_en", ring_wr_en, 0);
        check_val("reset_frame_done", frame_done, 0);
        check_val("reset_ch_err", ch_err, 0);
        check_val("reset_disp", disp_wr_en, 0);
        check_val("reset_diff", $signed(sample_diff), 0);
        check_val("reset_rd_addr", ring_rd_addr, 0);

        send_frame(0, 100, 1'b0, -1);
        send_frame(0, -7, 1'b0, -1);

        for (int i = 0; i < 3; i++) begin
            send_frame(0, rand_word(), 1'b0, -1);
            send_frame(1, rand_word(), 1'b0, -1);
        end

        // Extreme operands on ch2: first ring wrap hits both overflow directions.
        send_frame(2, -32768, 1'b0, -1);
        send_frame(2, 32767, 1'b0, -1);
        for (int i = 2; i < F; i++) send_frame(2, rand_word(), 1'b0, -1);
        send_frame(2, 32767, 1'b0, -1);
        send_frame(2, -32768, 1'b0, -1);

        send_frame(1, rand_word(), 1'b1, -1);
        send_bad_ch();
        send_frame(1, rand_word(), 1'b0, F / 2);
        send_frame(1, rand_word(), 1'b0, -1);
        send_frame(0, rand_word(), 1'b0, -1);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0) send_bad_ch();
            else send_frame(int'($urandom_range(0, NC - 1)), rand_word(),
                            1'($urandom_range(0, 3) == 0), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stft_sdft_sequencer.md
Name: stft_sdft_sequencer

Overview:
Multi-channel sliding-DFT sequencer, successor to the single-channel STFT control state machine. Per accepted sample it:
- reads the oldest sample of that channel from an external ring RAM;
- writes the new sample in its place;
- forms the difference (new minus oldest);
- sweeps every bin index for the twiddle address unit and bin accumulators;
- flags periodic display updates per channel.

It sits between the audio sample source and the twiddle/accumulator datapath.

Parameters:
- WORD_WIDTH, 16, signed sample width.
- FFT_SIZE, 256, bins per channel and ring depth per channel. Must be a power of two, ≥4.
- NUM_CH, 2, number of interleaved channels, ≥1.
- DISP_PERIOD, 4410, samples per channel between display-write sweeps, ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- sample_valid  in  1  sample offered.
- sample_ready  out  1  high only in IDLE.
- sample_ch  in  CH_W  channel of offered sample. CH_W = max(1, clog2(NUM_CH)).
- sample  in  WORD_WIDTH  signed new sample.
- ring_rd_addr  out  CH_W+AW  {ch, ptr} read address. AW = clog2(FFT_SIZE).
- oldest_sample  in  WORD_WIDTH  ring read data, one-cycle synchronous latency.
- ring_wr_en  out  1  ring write strobe.
- ring_wr_addr  out  CH_W+AW  ring write address.
- ring_wr_data  out  WORD_WIDTH  ring write data.
- sample_diff  out  WORD_WIDTH+1  signed difference, held for the whole sweep.
- bin_valid  out  1  bin_idx valid.
- bin_idx  out  AW  current bin.
- bin_ch  out  CH_W  channel of the sweep.
- disp_wr_en  out  1  display write enable, level over the sweep.
- frame_done  out  1  one-cycle pulse after the last bin.
- ch_err  out  1  one-cycle pulse when a sample with an illegal channel is dropped.

Behaviour:
- Reset values:
  - All outputs 0, except sample_ready = 1.
  - All per-channel write pointers = 0; all display counters = 0; state = IDLE.
- States: IDLE → LOAD → SWEEP → DONE → IDLE.
- IDLE:
  - Handshake is sample_valid && sample_ready.
  - On handshake with sample_ch < NUM_CH: latch sample and channel; drive ring_rd_addr = {ch, wr_ptr[ch]}; go to LOAD.
  - On handshake with sample_ch ≥ NUM_CH: pulse ch_err and stay in IDLE. No state change.
- LOAD (T+1):
  - oldest_sample is valid this cycle.
  - Register sample_diff = sext(sample) − sext(oldest_sample), computed at full WORD_WIDTH+1 width, so it never overflows.
  - Pulse ring_wr_en with ring_wr_addr = {ch, wr_ptr[ch]} and ring_wr_data = sample.
  - Register disp_wr_en = (disp_cnt[ch] == DISP_PERIOD−1).
  - Go to SWEEP.
- SWEEP (T+2 .. T+1+FFT_SIZE):
  - bin_valid = 1; bin_idx counts 0..FFT_SIZE−1; bin_ch = latched channel.
  - sample_diff and disp_wr_en are held constant.
  - On the last bin:
    - wr_ptr[ch] increments, wrapping FFT_SIZE−1 → 0.
    - disp_cnt[ch] increments, wrapping DISP_PERIOD−1 → 0.
    - Other channels are untouched.
- DONE (T+2+FFT_SIZE):
  - Pulse frame_done; bin_valid = 0; disp_wr_en cleared; sample_ready stays 0.
  - Next cycle: IDLE.
- Throughput: one sample per FFT_SIZE+3 cycles. sample_valid outside IDLE is ignored and not buffered.
- DISP_PERIOD = 1: disp_wr_en is asserted on every sweep.
- NUM_CH = 1: sample_ch is ignored; ch_err never fires.
- Reset asserted in any state:
  - Returns to reset values on the next edge.
  - An in-flight sweep is abandoned with no pointer or counter update.
  - A ring write issued in that LOAD cycle may still land in the ring.

Optional Feature:
Macro STFT_DIFF_SAT_EN.
- Defined: sample_diff is clamped to the signed WORD_WIDTH range, [−2^(W−1), 2^(W−1)−1], then sign-extended onto the WORD_WIDTH+1 port.
- Undefined: full-precision difference.
- Port widths are identical in both cases.

Decomposition:
- Package stft_pkg holds:
  - the state enum (IDLE, LOAD, SWEEP, DONE);
  - the CH_W/AW width helper function;
  - a helper for the display-counter width, clog2(DISP_PERIOD) with minimum 1.
- One natural sub-module, stft_ch_ctx: the per-channel bank of wr_ptr and disp_cnt.
  - Read port indexed by channel; increment strobe and channel select.

Test Plan:
- Reset, then one sample 100 on ch0 with an all-zero ring:
  - ring_wr_en at T+1 to addr 0, data 100.
  - sample_diff = 100.
  - bin_valid for 256 cycles, bin_idx 0..255.
  - frame_done at T+258; ring_rd_addr of the next ch0 sample = 1.
- Ring wrap: 257 samples on ch0 → 257th reads/writes addr 0; sample_diff = new − first sample.
- Channel interleave: alternate ch0/ch1 (NUM_CH=2), 3 each → ch1 addresses {1,0},{1,1},{1,2}; ch0 pointers are independent.
- Display period: DISP_PERIOD=4 → disp_wr_en high only on the 4th, 8th, … sweep of a channel; the other channel's counter is unaffected.
- Overflow: sample 32767, oldest −32768.
  - Without the macro: sample_diff = 65535.
  - With STFT_DIFF_SAT_EN: 32767.
  - Reversed operands: −65535 without the macro, −32768 with it.
- Robustness:
  - Reset at bin 100: idle next cycle, pointer unchanged.
  - sample_ch=3 with NUM_CH=2: ch_err pulse, no ring_wr_en.
  - sample_valid held during SWEEP is ignored.
